xillybus_mem_arbiter: RTL and testbench

Owns the 32×8 register bank behind the Xillybus seekable `mem_8` stream and shares it between the host (the `xillybus_core` `mem_8` port) and one local FPGA requester. It sits between `xillybus_core` and user logic, replacing a bare RAM on the `user_*_mem_8_*` nets. It enforces one memory access per cycle. It stalls the host through `full`/`empty` while local logic holds the grant, and bounds each side's burst for fairness.

---
 rtl/xillybus_pkg.sv | 18 +
 rtl/xillybus_mem_bank.sv | 45 ++++
 rtl/xillybus_mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_xillybus_mem_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/xillybus_pkg.sv
// Shared types and defaults for the mem_8 arbiter slice.
package xillybus_pkg;

    localparam int ADDR_W_DEF   = 5;
    localparam int DATA_W_DEF   = 8;
    localparam int HOLD_MAX_DEF = 4;

    typedef enum logic {
        ST_HOST  = 1'b0,
        ST_LOCAL = 1'b1
    } arb_state_t;

    // Burst counter width; a HOLD_MAX of 1 still needs a 1-bit counter.
    function automatic int cnt_width(input int hold_max);
        return (hold_max > 1) ? $clog2(hold_max) : 1;
    endfunction

endpackage

// File: rtl/xillybus_mem_bank.sv
// Single-port flop register bank with write enable and registered read.
// The read register is split per requester so host data stays put while
// the local side is reading.
module xillybus_mem_bank
    import xillybus_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic              re_host,
    output logic [DATA_W-1:0] host_rdata,
    output logic [DATA_W-1:0] loc_rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage: writes commit at the end of the access cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Registered read; a same-cycle write is not visible (old data returned).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            host_rdata <= '0;
            loc_rdata  <= '0;
        end else if (re) begin
            if (re_host) host_rdata <= mem[addr];
            else         loc_rdata  <= mem[addr];
        end
    end

endmodule

// File: rtl/xillybus_mem_arbiter.sv
// Shares the mem_8 register bank between the Xillybus host stream and one
// local requester: one access per cycle, host stalled via full/empty while
// local holds the grant, bursts bounded by HOLD_MAX when the other side waits.
module xillybus_mem_arbiter
    import xillybus_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int HOLD_MAX = HOLD_MAX_DEF
) (
    input  logic              bus_clk,
    input  logic              trn_reset_n,
    input  logic [ADDR_W-1:0] user_mem_8_addr,
    input  logic              user_mem_8_addr_update,
    input  logic              user_w_mem_8_wren,
    input  logic [DATA_W-1:0] user_w_mem_8_data,
    output logic              user_w_mem_8_full,
    input  logic              user_w_mem_8_open,
    input  logic              user_r_mem_8_rden,
    output logic [DATA_W-1:0] user_r_mem_8_data,
    output logic              user_r_mem_8_empty,
    output logic              user_r_mem_8_eof,
    input  logic              user_r_mem_8_open,
    input  logic              loc_req,
    input  logic              loc_we,
    input  logic [ADDR_W-1:0] loc_addr,
    input  logic [DATA_W-1:0] loc_wdata,
    output logic              loc_gnt,
    output logic              loc_rvalid,
    output logic [DATA_W-1:0] loc_rdata
);

    localparam int              CNT_W     = cnt_width(HOLD_MAX);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

    arb_state_t        state;
    logic              full_q;
    logic              gnt_q;
    logic              eof_q;
    logic              rvalid_q;
    logic [CNT_W-1:0]  hcnt;
    logic [CNT_W-1:0]  lcnt;
    logic [ADDR_W-1:0] haddr;

    logic              is_local;
    logic              any_open;
    logic              host_strobe;
    logic              loc_acc;
    logic              go_local;
    logic              go_host;
    logic [ADDR_W-1:0] eff_haddr;
    logic [ADDR_W-1:0] bank_addr;
    logic [DATA_W-1:0] bank_wdata;
    logic              bank_we;
    logic              bank_re;

    assign is_local    = (state == ST_LOCAL);
    assign any_open    = user_w_mem_8_open | user_r_mem_8_open;
    assign host_strobe = !is_local && (user_w_mem_8_wren || user_r_mem_8_rden);
    assign loc_acc     = is_local && loc_req;

    // A same-cycle address load takes effect for the access in that cycle.
    assign eff_haddr = user_mem_8_addr_update ? user_mem_8_addr : haddr;

    // Host yields when idle, at the end of its burst, or when nobody is open.
    assign go_local = !is_local && loc_req &&
                      (!host_strobe || (hcnt == HOLD_LAST) || !any_open);
    // Local yields when it stops asking, or at burst end if the host is open.
    assign go_host  = is_local &&
                      (!loc_req || ((lcnt == HOLD_LAST) && loc_acc && any_open));

    assign bank_addr  = is_local ? loc_addr  : eff_haddr;
    assign bank_wdata = is_local ? loc_wdata : user_w_mem_8_data;
    assign bank_we    = is_local ? (loc_req && loc_we)  : user_w_mem_8_wren;
    assign bank_re    = is_local ? (loc_req && !loc_we) : user_r_mem_8_rden;

    // Grant FSM with burst counters and registered stall/grant outputs.
    always_ff @(posedge bus_clk or negedge trn_reset_n) begin
        if (!trn_reset_n) begin
            state  <= ST_HOST;
            full_q <= 1'b0;
            gnt_q  <= 1'b0;
            hcnt   <= '0;
            lcnt   <= '0;
        end else begin
            if (go_local || go_host) begin
                state  <= go_local ? ST_LOCAL : ST_HOST;
                full_q <= go_local;
                gnt_q  <= go_local;
                hcnt   <= '0;
                lcnt   <= '0;
            end else begin
                if (host_strobe && hcnt != HOLD_LAST) hcnt <= hcnt + 1'b1;
                if (loc_acc && lcnt != HOLD_LAST)     lcnt <= lcnt + 1'b1;
            end
        end
    end

    // Host seek pointer: load on addr_update, post-increment per host access.
    always_ff @(posedge bus_clk or negedge trn_reset_n) begin
        if (!trn_reset_n) begin
            haddr <= '0;
        end else if (host_strobe) begin
            haddr <= eff_haddr + 1'b1;
        end else if (user_mem_8_addr_update) begin
            haddr <= user_mem_8_addr;
        end
    end

    // Local read valid pulse and the registered constant eof.
    always_ff @(posedge bus_clk or negedge trn_reset_n) begin
        if (!trn_reset_n) begin
            rvalid_q <= 1'b0;
            eof_q    <= 1'b0;
        end else begin
            rvalid_q <= loc_acc && !loc_we;
            eof_q    <= 1'b0;
        end
    end

    xillybus_mem_bank #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_bank (
        .clk        (bus_clk),
        .rst_n      (trn_reset_n),
        .addr       (bank_addr),
        .we         (bank_we),
        .wdata      (bank_wdata),
        .re         (bank_re),
        .re_host    (!is_local),
        .host_rdata (user_r_mem_8_data),
        .loc_rdata  (loc_rdata)
    );

    assign user_w_mem_8_full  = full_q;
    assign user_r_mem_8_empty = full_q;
    assign user_r_mem_8_eof   = eof_q;
    assign loc_gnt            = gnt_q;
    assign loc_rvalid         = rvalid_q;

endmodule

// File: tb/tb_xillybus_mem_arbiter.sv
// Directed bench for xillybus_mem_arbiter (defaults: 32x8 bank, HOLD_MAX 4).
module tb_xillybus_mem_arbiter;

    logic       bus_clk;
    logic       trn_reset_n;
    logic [4:0] user_mem_8_addr;
    logic       user_mem_8_addr_update;
    logic       user_w_mem_8_wren;
    logic [7:0] user_w_mem_8_data;
    logic       user_w_mem_8_full;
    logic       user_w_mem_8_open;
    logic       user_r_mem_8_rden;
    logic [7:0] user_r_mem_8_data;
    logic       user_r_mem_8_empty;
    logic       user_r_mem_8_eof;
    logic       user_r_mem_8_open;
    logic       loc_req;
    logic       loc_we;
    logic [4:0] loc_addr;
    logic [7:0] loc_wdata;
    logic       loc_gnt;
    logic       loc_rvalid;
    logic [7:0] loc_rdata;

    int total = 0;
    int bad   = 0;

    xillybus_mem_arbiter dut (
        .bus_clk                (bus_clk),
        .trn_reset_n            (trn_reset_n),
        .user_mem_8_addr        (user_mem_8_addr),
        .user_mem_8_addr_update (user_mem_8_addr_update),
        .user_w_mem_8_wren      (user_w_mem_8_wren),
        .user_w_mem_8_data      (user_w_mem_8_data),
        .user_w_mem_8_full      (user_w_mem_8_full),
        .user_w_mem_8_open      (user_w_mem_8_open),
        .user_r_mem_8_rden      (user_r_mem_8_rden),
        .user_r_mem_8_data      (user_r_mem_8_data),
        .user_r_mem_8_empty     (user_r_mem_8_empty),
        .user_r_mem_8_eof       (user_r_mem_8_eof),
        .user_r_mem_8_open      (user_r_mem_8_open),
        .loc_req                (loc_req),
        .loc_we                 (loc_we),
        .loc_addr               (loc_addr),
        .loc_wdata              (loc_wdata),
        .loc_gnt                (loc_gnt),
        .loc_rvalid             (loc_rvalid),
        .loc_rdata              (loc_rdata)
    );

    initial bus_clk = 1'b0;
    always #5 bus_clk = ~bus_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge bus_clk);
        #1;
    endtask

    task automatic host_write(input logic [4:0] a, input logic upd, input logic [7:0] d);
        user_mem_8_addr        = a;
        user_mem_8_addr_update = upd;
        user_w_mem_8_wren      = 1'b1;
        user_w_mem_8_data      = d;
        step();
        user_mem_8_addr_update = 1'b0;
        user_w_mem_8_wren      = 1'b0;
    endtask

    task automatic host_read(input logic [4:0] a, input logic upd, input logic [7:0] exp,
                             input string tag);
        user_mem_8_addr        = a;
        user_mem_8_addr_update = upd;
        user_r_mem_8_rden      = 1'b1;
        step();
        user_mem_8_addr_update = 1'b0;
        user_r_mem_8_rden      = 1'b0;
        chk(tag, user_r_mem_8_data, exp);
    endtask

    initial begin
        logic [23:0] pat;
        int          nw;
        int          gcnt;

        trn_reset_n            = 1'b0;
        user_mem_8_addr        = '0;
        user_mem_8_addr_update = 1'b0;
        user_w_mem_8_wren      = 1'b0;
        user_w_mem_8_data      = '0;
        user_w_mem_8_open      = 1'b1;
        user_r_mem_8_rden      = 1'b0;
        user_r_mem_8_open      = 1'b1;
        loc_req                = 1'b0;
        loc_we                 = 1'b0;
        loc_addr               = '0;
        loc_wdata              = '0;

        // Reset state
        step();
        step();
        chk("rst_full",   user_w_mem_8_full,  1'b0);
        chk("rst_empty",  user_r_mem_8_empty, 1'b0);
        chk("rst_eof",    user_r_mem_8_eof,   1'b0);
        chk("rst_gnt",    loc_gnt,            1'b0);
        chk("rst_rvalid", loc_rvalid,         1'b0);
        chk("rst_rdata",  loc_rdata,          8'h00);
        chk("rst_hdata",  user_r_mem_8_data,  8'h00);
        trn_reset_n = 1'b1;
        step();

        // Host round-trip at 3,4; the pointer then sits at 5
        host_write(5'd3, 1'b1, 8'hA1);
        host_write(5'd0, 1'b0, 8'hB2);
        host_read(5'd3, 1'b1, 8'hA1, "rt_rd3");
        host_read(5'd0, 1'b0, 8'hB2, "rt_rd4");
        step();
        chk("rt_hold", user_r_mem_8_data, 8'hB2);
        host_write(5'd0, 1'b0, 8'hC3);
        host_read(5'd5, 1'b1, 8'hC3, "rt_haddr5");

        // Address wrap 31 -> 0
        host_write(5'd31, 1'b1, 8'h11);
        host_write(5'd0,  1'b0, 8'h22);
        host_read(5'd31, 1'b1, 8'h11, "wrap_31");
        host_read(5'd0,  1'b0, 8'h22, "wrap_0");

        // Host closed: local keeps the grant; local read of addr 3
        user_w_mem_8_open = 1'b0;
        user_r_mem_8_open = 1'b0;
        loc_req  = 1'b1;
        loc_we   = 1'b0;
        loc_addr = 5'd3;
        step();
        chk("cl_gnt",  loc_gnt,           1'b1);
        chk("cl_full", user_w_mem_8_full, 1'b1);
        step();
        chk("cl_rvalid", loc_rvalid, 1'b1);
        chk("cl_rdata",  loc_rdata,  8'hA1);
        gcnt = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (loc_gnt === 1'b1) gcnt++;
        end
        chk("cl_gnt_held", gcnt, 8);
        loc_req = 1'b0;
        step();
        chk("cl_release_gnt",  loc_gnt,    1'b0);
        chk("cl_release_rval", loc_rvalid, 1'b0);
        user_w_mem_8_open = 1'b1;
        user_r_mem_8_open = 1'b1;

        // Switch-cycle strobe: 4th host write coincides with loc_req rising
        host_write(5'd12, 1'b1, 8'h71);
        host_write(5'd0,  1'b0, 8'h72);
        host_write(5'd0,  1'b0, 8'h73);
        loc_req   = 1'b1;
        loc_we    = 1'b1;
        loc_addr  = 5'd10;
        loc_wdata = 8'h5A;
        host_write(5'd0, 1'b0, 8'h74);
        chk("sw_full", user_w_mem_8_full, 1'b1);
        chk("sw_gnt",  loc_gnt,           1'b1);
        step();
        loc_req = 1'b0;
        step();
        chk("sw_back", user_w_mem_8_full, 1'b0);
        host_read(5'd15, 1'b1, 8'h74, "sw_hostwr");
        host_read(5'd10, 1'b1, 8'h5A, "sw_locwr");

        // One idle local bounce so the host burst count starts fresh
        loc_req = 1'b1;
        loc_we  = 1'b0;
        step();
        loc_req = 1'b0;
        step();

        // Fairness: host streams writes from addr 8, local writes addr 20
        loc_req   = 1'b1;
        loc_we    = 1'b1;
        loc_addr  = 5'd20;
        loc_wdata = 8'hEE;
        nw = 0;
        for (int i = 0; i < 24; i++) begin
            pat[i]                 = user_w_mem_8_full;
            user_mem_8_addr        = 5'd8;
            user_mem_8_addr_update = (i == 0);
            user_w_mem_8_wren      = !user_w_mem_8_full;
            user_w_mem_8_data      = 8'h30 + 8'(nw);
            step();
            if (pat[i] == 1'b0) nw++;
        end
        user_w_mem_8_wren      = 1'b0;
        user_mem_8_addr_update = 1'b0;
        loc_req                = 1'b0;
        step();
        chk("fair_pattern", pat, 24'hF0F0F0);
        chk("fair_nwrites", nw, 12);
        for (int k = 0; k < 12; k++)
            host_read(5'(8 + k), 1'b1, 8'h30 + 8'(k), $sformatf("fair_rd%0d", k));
        host_read(5'd20, 1'b1, 8'hEE, "fair_loc");

        // Async reset with a local read in flight
        loc_req  = 1'b1;
        loc_we   = 1'b0;
        loc_addr = 5'd3;
        step();
        step();
        chk("ar_pre_rvalid", loc_rvalid, 1'b1);
        #2;
        trn_reset_n = 1'b0;
        #1;
        chk("ar_rvalid", loc_rvalid,        1'b0);
        chk("ar_full",   user_w_mem_8_full, 1'b0);
        chk("ar_gnt",    loc_gnt,           1'b0);
        loc_req = 1'b0;
        step();
        trn_reset_n = 1'b1;
        step();
        host_read(5'd3,  1'b1, 8'h00, "ar_mem3");
        host_read(5'd12, 1'b1, 8'h00, "ar_mem12");
        host_read(5'd31, 1'b1, 8'h00, "ar_mem31");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
